// File: rtl/lcm_init_seq.sv
// lcm_init_seq: walks an LCM parameter ROM and streams DCS command
// packets, honouring delay records, to a DSI packet builder.
module lcm_init_seq #(
  parameter int ROM_AW    = 10,
  parameter int MS_CYCLES = 50000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  output logic [ROM_AW-1:0] rom_addr,
  input  logic [7:0]        rom_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [7:0]        out_data,
  output logic              out_sop,
  output logic              out_eop,
  output logic [7:0]        out_len,
  output logic              busy,
  output logic              done,
  output logic              error
);
  localparam int DW = $clog2(255 * MS_CYCLES + 1);
  localparam logic [DW-1:0] MS = DW'(MS_CYCLES);
  localparam logic [ROM_AW:0] ONE = 1;

  typedef enum logic [2:0] {
    IDLE, RD_LEN, RD_CMD, SEND_CMD,
    SEND_PAR, DELAY, DONE, ERR
  } state_t;

  state_t state, state_nx;

  logic [ROM_AW:0] ptr;
  logic            pend;
  logic            armed;
  logic [DW-1:0]   dcnt;
  logic [8:0]      fetch_rem;
  logic [7:0]      arr_cnt;
  logic [7:0]      sk_data;
  logic            sk_sop;
  logic            sk_eop;
  logic            sk_valid;
  logic [1:0]      occ;
  logic            go;
  logic            pop;
  logic            want;
  logic            issue;
  logic            ovf;
  logic            stream;
  logic            arr_sop;
  logic            arr_eop;

  assign rom_addr = ptr[ROM_AW-1:0];
  assign ovf      = ptr[ROM_AW];
  assign pop      = out_valid & out_ready;
  assign arr_sop  = (arr_cnt == 8'd0);
  assign arr_eop  = (arr_cnt == out_len);
  assign stream   = (state == RD_CMD) ||
                    (state == SEND_CMD) ||
                    (state == SEND_PAR);
  // bytes held or in flight after this cycle's pop; capped at two
  assign occ = 2'(out_valid) + 2'(sk_valid)
             + 2'(pend) - 2'(pop);

  always_comb begin
    state_nx = state;
    want     = 1'b0;
    go       = 1'b0;
    unique case (state)
      IDLE, DONE, ERR: begin
        go = start & armed;
        if (go) state_nx = RD_LEN;
      end
      RD_LEN: begin
        if (pend) begin
          if (rom_data == 8'hFF)
            state_nx = DONE;
          else if (rom_data == 8'hFE)
            state_nx = DELAY;
          else
            state_nx = RD_CMD;
        end else begin
          want = 1'b1;
        end
      end
      DELAY: begin
        if (dcnt != '0) begin
          if (dcnt == DW'(1)) state_nx = RD_LEN;
        end else if (pend) begin
          if (rom_data == 8'h00) state_nx = RD_LEN;
        end else begin
          want = 1'b1;
        end
      end
      RD_CMD, SEND_CMD, SEND_PAR: begin
        want = (fetch_rem != 9'd0) && (occ <= 2'd1);
        if (state == RD_CMD) begin
          if (pend) state_nx = SEND_CMD;
        end else if (pop) begin
          if (out_eop)
            state_nx = RD_LEN;
          else
            state_nx = SEND_PAR;
        end
      end
    endcase
    issue = want & ~ovf;
    if (want & ovf) state_nx = ERR;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      ptr       <= '0;
      pend      <= 1'b0;
      armed     <= 1'b0;
      dcnt      <= '0;
      fetch_rem <= '0;
      arr_cnt   <= '0;
      sk_data   <= '0;
      sk_sop    <= 1'b0;
      sk_eop    <= 1'b0;
      sk_valid  <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_sop   <= 1'b0;
      out_eop   <= 1'b0;
      out_len   <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      error     <= 1'b0;
    end else begin
      state <= state_nx;
      armed <= 1'b1;
      pend  <= issue;
      if (issue) ptr <= ptr + ONE;
      if (go) begin
        ptr   <= '0;
        busy  <= 1'b1;
        done  <= 1'b0;
        error <= 1'b0;
      end
      if (state == RD_LEN && pend) begin
        if (rom_data == 8'hFF) begin
          busy <= 1'b0;
          done <= 1'b1;
        end else if (rom_data != 8'hFE) begin
          out_len   <= rom_data;
          fetch_rem <= {1'b0, rom_data} + 9'd1;
          arr_cnt   <= '0;
        end
      end
      if (state == DELAY) begin
        if (dcnt != '0)
          dcnt <= dcnt - DW'(1);
        else if (pend)
          dcnt <= DW'(rom_data) * MS;
      end
      if (stream) begin
        if (issue) fetch_rem <= fetch_rem - 9'd1;
        if (pend) arr_cnt <= arr_cnt + 8'd1;
        // two-entry buffer: out regs, then skid behind them
        if (!out_valid) begin
          if (pend) begin
            out_valid <= 1'b1;
            out_data  <= rom_data;
            out_sop   <= arr_sop;
            out_eop   <= arr_eop;
          end
        end else if (pop) begin
          if (sk_valid) begin
            out_data <= sk_data;
            out_sop  <= sk_sop;
            out_eop  <= sk_eop;
            sk_valid <= 1'b0;
          end else if (pend) begin
            out_data <= rom_data;
            out_sop  <= arr_sop;
            out_eop  <= arr_eop;
          end else begin
            out_valid <= 1'b0;
          end
        end else if (pend) begin
          sk_data  <= rom_data;
          sk_sop   <= arr_sop;
          sk_eop   <= arr_eop;
          sk_valid <= 1'b1;
        end
      end
      if (state_nx == ERR && state != ERR) begin
        busy      <= 1'b0;
        error     <= 1'b1;
        out_valid <= 1'b0;
        sk_valid  <= 1'b0;
      end
    end
  end

endmodule
